load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory pipeline stage. Non-memory instructions pass straight
//             through with one cycle of latency; loads and stores issue a
//             single request/acknowledge transaction on the data-memory port
//             and stall upstream until it completes. Stores are lane-formatted
//             (strobes plus replicated data). Loads are lane-selected and then
//             sign- or zero-extended.
//  Options  : MISALIGN_TRAP_EN - when defined, a misaligned access issues no
//             memory request. Instead it produces a one-cycle misaligned_out
//             flag, with rd_value_out carrying the faulting address. When it
//             is undefined, misaligned_out stays 0 and the low address bits
//             are used only to select lanes.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  instr_id_in,
    input  logic        rd_valid_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic        rd_valid_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_value_out,
    output logic [5:0]  instr_id_out,
    output logic [31:0] mem_data_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_wstrb_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        misaligned_out
);

    // Decoded instruction IDs for memory operations
    localparam logic [5:0] c_INSTR_LB  = 6'd10;
    localparam logic [5:0] c_INSTR_LH  = 6'd11;
    localparam logic [5:0] c_INSTR_LW  = 6'd12;
    localparam logic [5:0] c_INSTR_LBU = 6'd13;
    localparam logic [5:0] c_INSTR_LHU = 6'd14;
    localparam logic [5:0] c_INSTR_SB  = 6'd15;
    localparam logic [5:0] c_INSTR_SH  = 6'd16;
    localparam logic [5:0] c_INSTR_SW  = 6'd17;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state;

    // Request context held for the duration of a memory access
    logic [5:0]  r_id;
    logic        r_rd_valid;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_eff_addr;
    logic        r_is_store;

    // Registered outputs
    logic        r_rd_valid_out;
    logic [4:0]  r_rd_addr_out;
    logic [31:0] r_rd_value_out;
    logic [5:0]  r_instr_id_out;
    logic [31:0] r_mem_data_out;
    logic        r_mem_we_out;
    logic [31:0] r_mem_addr_out;
    logic [31:0] r_mem_wdata_out;
    logic [3:0]  r_mem_wstrb_out;
    logic        r_misaligned_out;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_trap;
    logic        w_mem_go;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // Classify the incoming instruction as load, store or neither
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (instr_id_in)
            c_INSTR_LB, c_INSTR_LH, c_INSTR_LW,
            c_INSTR_LBU, c_INSTR_LHU: w_is_load  = 1'b1;
            c_INSTR_SB, c_INSTR_SH,
            c_INSTR_SW:               w_is_store = 1'b1;
            default: ;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;

    // Halfword accesses need bit 0 clear; word accesses need bits [1:0] clear
    always_comb begin
        w_misaligned = 1'b0;
        case (instr_id_in)
            c_INSTR_LH, c_INSTR_LHU, c_INSTR_SH: w_misaligned = alu_result_in[0];
            c_INSTR_LW, c_INSTR_SW:              w_misaligned = |alu_result_in[1:0];
            default: ;
        endcase
    end

    assign w_trap = (r_state == IDLE) && valid_in && w_is_mem && w_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    // A memory access that will actually go out on the bus
    assign w_mem_go  = (r_state == IDLE) && valid_in && w_is_mem && !w_trap;

    // Hold upstream on acceptance of an access and until its acknowledge
    assign stall_out = w_mem_go || ((r_state == WAIT) && !mem_ack_in);

    // Store lane formatting: strobes from the low address bits, data replicated
    always_comb begin
        w_st_wstrb = 4'b0000;
        w_st_wdata = 32'h0000_0000;
        case (instr_id_in)
            c_INSTR_SB: begin
                w_st_wstrb = 4'b0001 << alu_result_in[1:0];
                w_st_wdata = {4{rs2_value_in[7:0]}};
            end
            c_INSTR_SH: begin
                w_st_wstrb = alu_result_in[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{rs2_value_in[15:0]}};
            end
            c_INSTR_SW: begin
                w_st_wstrb = 4'b1111;
                w_st_wdata = rs2_value_in;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension using the latched address and ID
    always_comb begin
        case (r_eff_addr[1:0])
            2'd0:    w_ld_byte = mem_rdata_in[7:0];
            2'd1:    w_ld_byte = mem_rdata_in[15:8];
            2'd2:    w_ld_byte = mem_rdata_in[23:16];
            default: w_ld_byte = mem_rdata_in[31:24];
        endcase
        w_ld_half = r_eff_addr[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
        case (r_id)
            c_INSTR_LB:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_INSTR_LBU: w_ld_data = {24'h00_0000, w_ld_byte};
            c_INSTR_LH:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            c_INSTR_LHU: w_ld_data = {16'h0000, w_ld_half};
            c_INSTR_LW:  w_ld_data = mem_rdata_in;
            default:     w_ld_data = 32'h0000_0000;
        endcase
    end

    // Control FSM plus all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_id             <= 6'd0;
            r_rd_valid       <= 1'b0;
            r_rd_addr        <= 5'd0;
            r_eff_addr       <= 32'h0000_0000;
            r_is_store       <= 1'b0;
            r_rd_valid_out   <= 1'b0;
            r_rd_addr_out    <= 5'd0;
            r_rd_value_out   <= 32'h0000_0000;
            r_instr_id_out   <= 6'd0;
            r_mem_data_out   <= 32'h0000_0000;
            r_mem_we_out     <= 1'b0;
            r_mem_addr_out   <= 32'h0000_0000;
            r_mem_wdata_out  <= 32'h0000_0000;
            r_mem_wstrb_out  <= 4'b0000;
            r_misaligned_out <= 1'b0;
        end else begin
            // Empty output slot unless something is accepted or completed
            r_rd_valid_out   <= 1'b0;
            r_misaligned_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        if (w_trap) begin
                            r_rd_addr_out    <= rd_addr_in;
                            r_rd_value_out   <= alu_result_in;
                            r_instr_id_out   <= instr_id_in;
                            r_mem_data_out   <= 32'h0000_0000;
                            r_misaligned_out <= 1'b1;
                        end else if (w_is_mem) begin
                            r_id            <= instr_id_in;
                            r_rd_valid      <= rd_valid_in;
                            r_rd_addr       <= rd_addr_in;
                            r_eff_addr      <= alu_result_in;
                            r_is_store      <= w_is_store;
                            r_mem_we_out    <= w_is_store;
                            r_mem_addr_out  <= {alu_result_in[31:2], 2'b00};
                            r_mem_wdata_out <= w_st_wdata;
                            r_mem_wstrb_out <= w_st_wstrb;
                            r_state         <= WAIT;
                        end else begin
                            r_rd_valid_out <= rd_valid_in;
                            r_rd_addr_out  <= rd_addr_in;
                            r_rd_value_out <= alu_result_in;
                            r_instr_id_out <= instr_id_in;
                            r_mem_data_out <= 32'h0000_0000;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack_in) begin
                        r_rd_valid_out <= r_rd_valid && !r_is_store;
                        r_rd_addr_out  <= r_rd_addr;
                        r_rd_value_out <= r_eff_addr;
                        r_instr_id_out <= r_id;
                        r_mem_data_out <= w_ld_data;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req_out    = (r_state == WAIT);
    assign rd_valid_out   = r_rd_valid_out;
    assign rd_addr_out    = r_rd_addr_out;
    assign rd_value_out   = r_rd_value_out;
    assign instr_id_out   = r_instr_id_out;
    assign mem_data_out   = r_mem_data_out;
    assign mem_we_out     = r_mem_we_out;
    assign mem_addr_out   = r_mem_addr_out;
    assign mem_wdata_out  = r_mem_wdata_out;
    assign mem_wstrb_out  = r_mem_wstrb_out;
    assign misaligned_out = r_misaligned_out;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit. It covers
//             pass-through, load extension, store formatting, back-to-back
//             flow, reset in WAIT and misaligned handling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [5:0] c_ID_ADD = 6'd1;
    localparam logic [5:0] c_ID_LB  = 6'd10;
    localparam logic [5:0] c_ID_LH  = 6'd11;
    localparam logic [5:0] c_ID_LW  = 6'd12;
    localparam logic [5:0] c_ID_LBU = 6'd13;
    localparam logic [5:0] c_ID_LHU = 6'd14;
    localparam logic [5:0] c_ID_SB  = 6'd15;
    localparam logic [5:0] c_ID_SH  = 6'd16;
    localparam logic [5:0] c_ID_SW  = 6'd17;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  instr_id_in;
    logic        rd_valid_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_value_in;
    logic        stall_out;
    logic        rd_valid_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_value_out;
    logic [5:0]  instr_id_out;
    logic [31:0] mem_data_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_wstrb_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        misaligned_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .instr_id_in    (instr_id_in),
        .rd_valid_in    (rd_valid_in),
        .rd_addr_in     (rd_addr_in),
        .alu_result_in  (alu_result_in),
        .rs2_value_in   (rs2_value_in),
        .stall_out      (stall_out),
        .rd_valid_out   (rd_valid_out),
        .rd_addr_out    (rd_addr_out),
        .rd_value_out   (rd_value_out),
        .instr_id_out   (instr_id_out),
        .mem_data_out   (mem_data_out),
        .mem_req_out    (mem_req_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_wstrb_out  (mem_wstrb_out),
        .mem_ack_in     (mem_ack_in),
        .mem_rdata_in   (mem_rdata_in),
        .misaligned_out (misaligned_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] id, input logic rdv, input logic [4:0] rda,
                         input logic [31:0] alu, input logic [31:0] rs2);
        valid_in      = 1'b1;
        instr_id_in   = id;
        rd_valid_in   = rdv;
        rd_addr_in    = rda;
        alu_result_in = alu;
        rs2_value_in  = rs2;
    endtask

    task automatic idle_inputs();
        valid_in      = 1'b0;
        instr_id_in   = 6'd0;
        rd_valid_in   = 1'b0;
        rd_addr_in    = 5'd0;
        alu_result_in = 32'h0;
        rs2_value_in  = 32'h0;
    endtask

    // Load with the acknowledge arriving 'delay' cycles after the request rises
    task automatic do_load(input logic [5:0] id, input logic [31:0] addr,
                           input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp);
        int stalls;
        logic [31:0] exp_addr;
        stalls   = 0;
        exp_addr = addr & 32'hFFFF_FFFC;
        drive(id, 1'b1, 5'd9, addr, 32'h0);
        #1 if (stall_out) stalls++;
        step();
        check("ld_req", 32'(mem_req_out), 32'd1);
        check("ld_addr", mem_addr_out, exp_addr);
        check("ld_we", 32'(mem_we_out), 32'd0);
        for (int i = 0; i < delay; i++) begin
            #1 if (stall_out) stalls++;
            step();
        end
        mem_ack_in   = 1'b1;
        mem_rdata_in = rdata;
        #1 if (stall_out) stalls++;
        step();
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        idle_inputs();
        check("ld_valid", 32'(rd_valid_out), 32'd1);
        check("ld_data", mem_data_out, exp);
        check("ld_rd", 32'(rd_addr_out), 32'd9);
        check("ld_id", 32'(instr_id_out), 32'(id));
        check("ld_mis", 32'(misaligned_out), 32'd0);
        check("ld_req_drop", 32'(mem_req_out), 32'd0);
        check("ld_stall_cycles", 32'(stalls), 32'(delay + 1));
        step();
        check("ld_pulse", 32'(rd_valid_out), 32'd0);
    endtask

    // Store acknowledged in the same cycle the request rises
    task automatic do_store(input logic [5:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        drive(id, 1'b1, 5'd4, addr, data);
        #1 check("st_stall_acc", 32'(stall_out), 32'd1);
        step();
        mem_ack_in = 1'b1;
        #1;
        check("st_req", 32'(mem_req_out), 32'd1);
        check("st_we", 32'(mem_we_out), 32'd1);
        check("st_addr", mem_addr_out, addr & 32'hFFFF_FFFC);
        check("st_wstrb", 32'(mem_wstrb_out), 32'(exp_strb));
        check("st_wdata", mem_wdata_out, exp_wdata);
        check("st_stall_ack", 32'(stall_out), 32'd0);
        step();
        mem_ack_in = 1'b0;
        idle_inputs();
        check("st_rdv", 32'(rd_valid_out), 32'd0);
        check("st_req_drop", 32'(mem_req_out), 32'd0);
        check("st_id", 32'(instr_id_out), 32'(id));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        idle_inputs();
        step();
        step();
        check("rst_rdv", 32'(rd_valid_out), 32'd0);
        check("rst_rda", 32'(rd_addr_out), 32'd0);
        check("rst_rval", rd_value_out, 32'd0);
        check("rst_id", 32'(instr_id_out), 32'd0);
        check("rst_mdata", mem_data_out, 32'd0);
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_we", 32'(mem_we_out), 32'd0);
        check("rst_addr", mem_addr_out, 32'd0);
        check("rst_wdata", mem_wdata_out, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb_out), 32'd0);
        check("rst_mis", 32'(misaligned_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        rst = 1'b0;
        step();

        // Acknowledge while idle must be ignored
        mem_ack_in = 1'b1;
        step();
        mem_ack_in = 1'b0;
        check("idle_ack_rdv", 32'(rd_valid_out), 32'd0);
        check("idle_ack_req", 32'(mem_req_out), 32'd0);

        // Non-memory pass-through with rd_valid_in low
        drive(c_ID_ADD, 1'b0, 5'd6, 32'h0000_0066, 32'h0);
        step();
        idle_inputs();
        check("add_norv", 32'(rd_valid_out), 32'd0);
        check("add_norv_val", rd_value_out, 32'h0000_0066);

        // Back-to-back ADD, LW, ADD
        drive(c_ID_ADD, 1'b1, 5'd1, 32'h0000_0011, 32'h0);
        #1 check("b2b_add1_stall", 32'(stall_out), 32'd0);
        step();
        check("b2b_add1_rdv", 32'(rd_valid_out), 32'd1);
        check("b2b_add1_val", rd_value_out, 32'h0000_0011);
        check("b2b_add1_rd", 32'(rd_addr_out), 32'd1);
        check("b2b_add1_id", 32'(instr_id_out), 32'(c_ID_ADD));
        check("b2b_add1_md", mem_data_out, 32'd0);
        drive(c_ID_LW, 1'b1, 5'd2, 32'h0000_0500, 32'h0);
        #1 check("b2b_lw_stall", 32'(stall_out), 32'd1);
        step();
        check("b2b_wait_rdv", 32'(rd_valid_out), 32'd0);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hDEAD_BEEF;
        #1 check("b2b_ack_stall", 32'(stall_out), 32'd0);
        step();
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        drive(c_ID_ADD, 1'b1, 5'd3, 32'h0000_0033, 32'h0);
        check("b2b_lw_rdv", 32'(rd_valid_out), 32'd1);
        check("b2b_lw_rd", 32'(rd_addr_out), 32'd2);
        check("b2b_lw_data", mem_data_out, 32'hDEAD_BEEF);
        #1 check("b2b_add2_stall", 32'(stall_out), 32'd0);
        step();
        idle_inputs();
        check("b2b_add2_rdv", 32'(rd_valid_out), 32'd1);
        check("b2b_add2_rd", 32'(rd_addr_out), 32'd3);
        check("b2b_add2_val", rd_value_out, 32'h0000_0033);
        check("b2b_add2_md", mem_data_out, 32'd0);
        step();
        check("b2b_end_rdv", 32'(rd_valid_out), 32'd0);

        // Loads: lane select and extension
        do_load(c_ID_LB,  32'h0000_1003, 32'h80FF_1234, 3, 32'hFFFF_FF80);
        do_load(c_ID_LHU, 32'h0000_4002, 32'h8001_0000, 0, 32'h0000_8001);
        do_load(c_ID_LH,  32'h0000_4002, 32'h8001_0000, 1, 32'hFFFF_8001);
        do_load(c_ID_LBU, 32'h0000_1001, 32'h0000_A500, 0, 32'h0000_00A5);
        do_load(c_ID_LB,  32'h0000_1000, 32'h0000_007F, 0, 32'h0000_007F);
        do_load(c_ID_LW,  32'h0000_1004, 32'h1234_5678, 2, 32'h1234_5678);

        // Stores: strobes and replicated data
        do_store(c_ID_SH, 32'h0000_2002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store(c_ID_SB, 32'h0000_0010, 32'h1234_5699, 4'b0001, 32'h9999_9999);
        do_store(c_ID_SB, 32'h0000_0013, 32'h1234_5699, 4'b1000, 32'h9999_9999);
        do_store(c_ID_SH, 32'h0000_0020, 32'hFFFF_1234, 4'b0011, 32'h1234_1234);
        do_store(c_ID_SW, 32'h0000_0030, 32'hA5A5_5A5A, 4'b1111, 32'hA5A5_5A5A);

        // Reset in WAIT with an acknowledge arriving the following cycle
        drive(c_ID_LW, 1'b1, 5'd8, 32'h0000_0600, 32'h0);
        step();
        check("rw_req", 32'(mem_req_out), 32'd1);
        rst = 1'b1;
        idle_inputs();
        step();
        rst          = 1'b0;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h1111_2222;
        check("rw_req_drop", 32'(mem_req_out), 32'd0);
        check("rw_rdv", 32'(rd_valid_out), 32'd0);
        check("rw_addr_clr", mem_addr_out, 32'd0);
        #1 check("rw_stall", 32'(stall_out), 32'd0);
        step();
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        check("rw_late_ack_rdv", 32'(rd_valid_out), 32'd0);
        check("rw_late_ack_req", 32'(mem_req_out), 32'd0);
        step();

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        drive(c_ID_LW, 1'b1, 5'd5, 32'h0000_3001, 32'h0);
        #1 check("mis_stall", 32'(stall_out), 32'd0);
        step();
        idle_inputs();
        check("mis_req", 32'(mem_req_out), 32'd0);
        check("mis_flag", 32'(misaligned_out), 32'd1);
        check("mis_rdv", 32'(rd_valid_out), 32'd0);
        check("mis_val", rd_value_out, 32'h0000_3001);
        step();
        check("mis_flag_drop", 32'(misaligned_out), 32'd0);
`else
        do_load(c_ID_LW, 32'h0000_3001, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
